// File: rtl/ram_unloader_if.sv
// rtl/ram_unloader_if.sv - RAM read port and output FIFO write port used by ram_unloader
interface ram_unloader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              rd_ram;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;
   logic              full;
   logic              wr_fifo;
   logic [DATA_W-1:0] fifo_wr_data;

   // The unloader drives reads into the RAM and writes into the FIFO.
   modport master (
      output rd_ram,
      output ram_rd_addr,
      input  ram_rd_data,
      input  full,
      output wr_fifo,
      output fifo_wr_data
   );

   // The RAM/FIFO side answers with read data and backpressure.
   modport slave (
      input  rd_ram,
      input  ram_rd_addr,
      output ram_rd_data,
      output full,
      input  wr_fifo,
      input  fifo_wr_data
   );
endinterface

// File: rtl/ram_unloader.sv
// rtl/ram_unloader.sv - walks result RAM addresses and pushes each word into the output FIFO
module ram_unloader #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int NUM_WORDS = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   ram_unloader_if.master  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      PUSH = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr, addr_next;
   logic [DATA_W-1:0] hold, hold_next;
   logic              rd_ram_c;
   logic              wr_fifo_c;
   logic              done_c;

   // State, address and captured word registers; async reset clears any partial block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         addr  <= '0;
         hold  <= '0;
      end else begin
         state <= state_next;
         addr  <= addr_next;
         hold  <= hold_next;
      end
   end

   // Next-state and output decode; the FIFO write is combinational from full so a
   // falling full lets the word go out in the same PUSH cycle.
   always_comb begin
      state_next = state;
      addr_next  = addr;
      hold_next  = hold;
      rd_ram_c   = 1'b0;
      wr_fifo_c  = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RD;
               addr_next  = '0;
            end
         end
         RD: begin
            rd_ram_c   = 1'b1;
            state_next = CAP;
         end
         CAP: begin
            hold_next  = bus.ram_rd_data;
            state_next = PUSH;
         end
         PUSH: begin
            if (!bus.full) begin
               wr_fifo_c = 1'b1;
               if (addr == LAST_ADDR) begin
                  state_next = DONE;
               end else begin
                  addr_next  = addr + 1'b1;
                  state_next = RD;
               end
            end
         end
         DONE: begin
            done_c     = 1'b1;
            addr_next  = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            addr_next  = '0;
         end
      endcase
   end

   assign bus.rd_ram       = rd_ram_c;
   assign bus.ram_rd_addr  = addr;
   assign bus.wr_fifo      = wr_fifo_c;
   assign bus.fifo_wr_data = hold;
   assign done             = done_c;
   assign busy             = (state != IDLE);

endmodule

// File: tb/tb_ram_unloader.sv
// tb/tb_ram_unloader.sv - scoreboard bench for ram_unloader with 16-word and 1-word instances
module tb_ram_unloader;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start16 = 1'b0, start1 = 1'b0;
   logic busy16, done16, busy1, done1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] ram16 [16];
   logic [7:0] ram1 [16];

   ev_t wq16[$], rq16[$], wq1[$], rq1[$];
   int  dq16[$], dq1[$];

   ram_unloader_if #(.DATA_W(8), .ADDR_W(4)) bus16 ();
   ram_unloader_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

   ram_unloader #(.DATA_W(8), .ADDR_W(4), .NUM_WORDS(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16),
      .busy(busy16), .done(done16), .bus(bus16.master)
   );

   ram_unloader #(.DATA_W(8), .ADDR_W(4), .NUM_WORDS(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .busy(busy1), .done(done1), .bus(bus1.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM models with one-cycle read latency
   always @(posedge clk) if (bus16.rd_ram) bus16.ram_rd_data <= ram16[bus16.ram_rd_addr];
   always @(posedge clk) if (bus1.rd_ram)  bus1.ram_rd_data  <= ram1[bus1.ram_rd_addr];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected event value 0x%0h at cycle %0d", name, act, cyc);
   endtask

   // Monitor for the 16-word instance
   always @(negedge clk) begin
      ev_t e;
      if (bus16.wr_fifo) begin
         if (wq16.size() == 0) unexpected("w16_extra", bus16.fifo_wr_data);
         else begin
            e = wq16.pop_front();
            cmp("w16_cyc", cyc, e.cyc);
            cmp("w16_data", bus16.fifo_wr_data, e.val);
         end
      end
      if (bus16.rd_ram) begin
         if (rq16.size() == 0) unexpected("rd16_extra", bus16.ram_rd_addr);
         else begin
            e = rq16.pop_front();
            cmp("rd16_cyc", cyc, e.cyc);
            cmp("rd16_addr", bus16.ram_rd_addr, e.val);
         end
      end
      if (done16) begin
         if (dq16.size() == 0) unexpected("done16_extra", cyc);
         else cmp("done16_cyc", cyc, dq16.pop_front());
      end
   end

   // Monitor for the 1-word instance
   always @(negedge clk) begin
      ev_t e;
      if (bus1.wr_fifo) begin
         if (wq1.size() == 0) unexpected("w1_extra", bus1.fifo_wr_data);
         else begin
            e = wq1.pop_front();
            cmp("w1_cyc", cyc, e.cyc);
            cmp("w1_data", bus1.fifo_wr_data, e.val);
         end
      end
      if (bus1.rd_ram) begin
         if (rq1.size() == 0) unexpected("rd1_extra", bus1.ram_rd_addr);
         else begin
            e = rq1.pop_front();
            cmp("rd1_cyc", cyc, e.cyc);
            cmp("rd1_addr", bus1.ram_rd_addr, e.val);
         end
      end
      if (done1) begin
         if (dq1.size() == 0) unexpected("done1_extra", cyc);
         else cmp("done1_cyc", cyc, dq1.pop_front());
      end
   end

   // Expected 16-word block starting at k; words from stall_word onward slip by stall_len
   task automatic push_run16(input int k, input int stall_word, input int stall_len);
      for (int i = 0; i < 16; i++) begin
         wq16.push_back('{k + 3 + 3*i + ((i >= stall_word) ? stall_len : 0), 8'(8'h10 + i)});
         rq16.push_back('{k + 1 + 3*i + ((i > stall_word) ? stall_len : 0), 8'(i)});
      end
      dq16.push_back(k + 49 + stall_len);
   endtask

   // One vector: start mask and full window relative to k (the cycle holding the first start)
   task automatic drive(input int sel, input int ncyc, input logic [127:0] smask,
                        input int flo, input int fhi, input int hold_chk);
      for (int j = 0; j < ncyc; j++) begin
         if (sel == 0) begin
            start16    = smask[j];
            bus16.full = (j >= flo && j <= fhi);
         end else begin
            start1     = smask[j];
            bus1.full  = (j >= flo && j <= fhi);
         end
         @(negedge clk);
         if (hold_chk >= 0 && j >= flo && j <= fhi) begin
            cmp("stall_data", (sel == 0) ? bus16.fifo_wr_data : bus1.fifo_wr_data, hold_chk);
            cmp("stall_wr",   (sel == 0) ? bus16.wr_fifo : bus1.wr_fifo, 0);
         end
         @(posedge clk); #1;
      end
      start16 = 1'b0; start1 = 1'b0; bus16.full = 1'b0; bus1.full = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      cmp({tag, "_rd16"},   bus16.rd_ram, 0);
      cmp({tag, "_wr16"},   bus16.wr_fifo, 0);
      cmp({tag, "_done16"}, done16, 0);
      cmp({tag, "_busy16"}, busy16, 0);
      cmp({tag, "_addr16"}, bus16.ram_rd_addr, 0);
      cmp({tag, "_data16"}, bus16.fifo_wr_data, 0);
      cmp({tag, "_busy1"},  busy1, 0);
      cmp({tag, "_data1"},  bus1.fifo_wr_data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [127:0] m;
      for (int a = 0; a < 16; a++) begin
         ram16[a] = 8'(8'h10 + a);
         ram1[a]  = 8'(8'h50 + a);
      end
      ram1[0] = 8'hA5;
      bus16.full = 1'b0;
      bus1.full  = 1'b0;

      // Reset with random inputs; start held into the release
      @(posedge clk); #1;
      for (int j = 0; j < 6; j++) begin
         start16    = (j == 5) ? 1'b1 : 1'($urandom);
         start1     = (j == 5) ? 1'b1 : 1'($urandom);
         bus16.full = 1'($urandom);
         bus1.full  = 1'($urandom);
         @(negedge clk);
         check_idle_outputs("reset");
         @(posedge clk); #1;
      end
      reset_n = 1'b1; start16 = 1'b0; start1 = 1'b0; bus16.full = 1'b0; bus1.full = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      cmp("post_reset_busy16", busy16, 0);
      cmp("post_reset_busy1", busy1, 0);

      // Full run, no backpressure
      k = cyc; push_run16(k, 99, 0);
      m = 128'd1;
      drive(0, 52, m, -1, -2, -1);
      cmp("run1_busy_after", busy16, 0);

      // Five cycles of full starting at word 2's PUSH
      k = cyc; push_run16(k, 2, 5);
      drive(0, 57, m, 9, 13, 8'h12);

      // start in RD, PUSH and DONE ignored; start right after DONE accepted
      k = cyc; push_run16(k, 99, 0); push_run16(k + 50, 99, 0);
      m = '0; m[0] = 1'b1; m[1] = 1'b1; m[3] = 1'b1; m[49] = 1'b1; m[50] = 1'b1;
      drive(0, 102, m, -1, -2, -1);

      // Reset at word 7's CAP
      k = cyc;
      for (int i = 0; i < 7; i++) wq16.push_back('{k + 3 + 3*i, 8'(8'h10 + i)});
      for (int i = 0; i < 8; i++) rq16.push_back('{k + 1 + 3*i, 8'(i)});
      m = 128'd1;
      drive(0, 23, m, -1, -2, -1);
      cmp("cap7_busy_before", busy16, 1);
      cmp("cap7_addr_before", bus16.ram_rd_addr, 7);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      k = cyc; push_run16(k, 99, 0);
      drive(0, 52, m, -1, -2, -1);

      // Single-word instance, then with three cycles of full in PUSH
      k = cyc;
      wq1.push_back('{k + 3, 8'hA5}); rq1.push_back('{k + 1, 8'h00}); dq1.push_back(k + 4);
      drive(1, 6, m, -1, -2, -1);
      k = cyc;
      wq1.push_back('{k + 6, 8'hA5}); rq1.push_back('{k + 1, 8'h00}); dq1.push_back(k + 7);
      drive(1, 9, m, 3, 5, 8'hA5);

      repeat (4) @(posedge clk);
      #1;
      cmp("left_w16", wq16.size(), 0);
      cmp("left_rd16", rq16.size(), 0);
      cmp("left_done16", dq16.size(), 0);
      cmp("left_w1", wq1.size(), 0);
      cmp("left_rd1", rq1.size(), 0);
      cmp("left_done1", dq1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_unloader.md
# ram_unloader

Drains a block of averaged results from the result RAM into a downstream byte FIFO. It is the reader-side counterpart of the averaging front-end controller, which pulls bytes out of the input FIFO and writes one averaged word to RAM per four bytes. On a `start` pulse it walks RAM addresses 0 to NUM_WORDS-1 and fetches each word (one-cycle RAM read latency). It pushes each word into the output FIFO, stalling on `full` without losing or duplicating data, and pulses `done` when the block is emptied.

## Interface
- DATA_W, 8, width of RAM words and FIFO write data
- ADDR_W, 4, RAM address width
- NUM_WORDS, 16, words transferred per `start`; legal range 1 to 2^ADDR_W
- clk  in  1  clock, all state changes on posedge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a transfer; ignored unless idle
- rd_ram  out  1  RAM read enable; `ram_rd_data` is valid the cycle after
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data
- full  in  1  output FIFO full; no write may occur while high
- wr_fifo  out  1  output FIFO write strobe, one word per high cycle
- fifo_wr_data  out  DATA_W  output FIFO write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the last word is written

## Operation
- Registers:
  - state: IDLE, RD, CAP, PUSH, DONE.
  - addr: ADDR_W bits, drives `ram_rd_addr`.
  - hold: DATA_W bits, drives `fifo_wr_data`.
- IDLE:
  - `start`=1 goes to RD with addr cleared to 0.
  - Otherwise stays in IDLE.
- RD: `rd_ram`=1. Always goes to CAP.
- CAP: hold is loaded from `ram_rd_data` at the end of the cycle. Always goes to PUSH.
- PUSH with `full`=0:
  - `wr_fifo`=1.
  - If addr==NUM_WORDS-1, go to DONE.
  - Otherwise increment addr and go to RD.
- PUSH with `full`=1:
  - `wr_fifo`=0 and the state stays PUSH.
  - hold and addr are unchanged.
- DONE: `done`=1. Always goes to IDLE. addr returns to 0.
- Output decode:
  - `wr_fifo` = (state==PUSH) & ~`full`. It is combinational from `full`.
  - `rd_ram` = (state==RD).
  - `done` = (state==DONE).
  - `busy` = (state!=IDLE).
- `start` while busy (RD, CAP, PUSH or DONE) has no effect. It is not queued.
- addr never exceeds NUM_WORDS-1 and never wraps mid-transfer. The increment uses ADDR_W-bit arithmetic.
- `ram_rd_addr` is stable from RD through the end of PUSH for each word.
- `fifo_wr_data` holds the last captured word until the next CAP.

## Timing
- Reset values: state IDLE, addr 0, hold 0. `rd_ram`, `wr_fifo`, `done` and `busy` are all 0. `ram_rd_addr`=0 and `fifo_wr_data`=0.
- Reset is honoured in any state, including mid-transfer. The next `start` restarts at address 0, and a partial block is not resumed.
- Cycle numbering, with `start` sampled at edge k:
  - RD during cycle k+1, with `rd_ram`=1 and `ram_rd_addr`=0.
  - CAP during k+2.
  - PUSH during k+3: `wr_fifo`=1 if `full`=0.
- Throughput: 3 cycles per word with no backpressure. Word i is written in cycle k+3+3i.
- `done` is high in cycle k+3·NUM_WORDS+1. `busy` is high from k+1 through that cycle inclusive.
- Each cycle of `full`=1 during PUSH adds one cycle of latency. `full` outside PUSH has no effect.
- `full` dropping in a PUSH cycle allows the write in that same cycle.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset: assert `reset_n`=0 with random inputs -> every output 0; `start` pulsed during reset -> no activity after release.
- Full run, NUM_WORDS=16, RAM[a]=0x10+a, `full`=0 -> 16 writes of 0x10 to 0x1F in cycles k+3, k+6 up to k+48; `done` in k+49 only; `rd_ram` seen at addresses 0 to 15 exactly once each.
- Backpressure: `full`=1 for 5 cycles from word 2's PUSH -> `wr_fifo` low those 5 cycles with `fifo_wr_data`=0x12 stable; written once when `full` falls; `done` at k+54; no duplicate or missing words.
- `start` pulsed in RD, PUSH and DONE cycles -> ignored, single 16-word sequence; `start` the cycle after DONE -> new transfer from address 0.
- Reset asserted at word 7's CAP -> outputs 0 immediately; next `start` writes 0x10 first.
- NUM_WORDS=1, RAM[0]=0xA5 -> one write of 0xA5 at k+3, `done` at k+4; with `full` held high 3 cycles in PUSH -> write at k+6, `done` at k+7.
